// File: rtl/note_key_encoder_if.sv
// Key/note bus between a keyboard front end and the note consumer.
interface note_key_encoder_if;
  logic [7:0] keys;
  logic [3:0] note;
  logic       note_valid;
  logic       note_change;

  modport master (output keys, input note, note_valid, note_change);
  modport slave  (input keys, output note, note_valid, note_change);
endinterface

// File: rtl/note_key_encoder.sv
// Piano key encoder: synchronize, debounce per key on a slow sample tick,
// then track the first-pressed key as the current note.

// Per-key debouncer: accepted level flips after DEB_COUNT consecutive
// differing samples taken on tick cycles.
module nke_key_deb #(
  parameter int DEB_COUNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic smp,
  output logic lvl
);
  localparam logic [3:0] CMAX = 4'(DEB_COUNT - 1);

  logic [3:0] cnt;

  // Count differing samples; any agreeing sample restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else if (tick) begin
      if (smp == lvl) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        cnt <= '0;
        lvl <= ~lvl;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

module note_key_encoder #(
  parameter int TICK_DIV  = 100000,
  parameter int DEB_COUNT = 4
) (
  input logic               clk,
  input logic               rst,
  note_key_encoder_if.slave bus
);
  localparam int NUM_KEYS = 8;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  logic [NUM_KEYS-1:0] s1, s2, lvl;
  logic [TW-1:0]       tcnt;
  logic                tick;
  logic [0:0]          st, st_n;
  logic [2:0]          hidx, hidx_n, low;
  logic                any;
  logic [3:0]          note_n;

  // Two-flop synchronizer on the raw keys.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.keys;
      s2 <= s1;
    end
  end

  // Free-running sample tick divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + TW'(1);
  end

  assign tick = (tcnt == TMAX);

  nke_key_deb #(.DEB_COUNT(DEB_COUNT)) u_deb [NUM_KEYS-1:0] (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .smp  (s2),
    .lvl  (lvl)
  );

  assign any = |lvl;

  // Lowest-index accepted key (scan high to low so the lowest wins).
  always_comb begin
    low = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (lvl[i]) low = 3'(i);
  end

  // Held key is sticky until released; then fall back to the lowest remaining.
  always_comb begin
    st_n   = st;
    hidx_n = hidx;
    case (st)
      IDLE: if (any) begin
        st_n   = HELD;
        hidx_n = low;
      end
      HELD: if (!lvl[hidx]) begin
        if (any) hidx_n = low;
        else     st_n   = IDLE;
      end
      default: st_n = IDLE;
    endcase
    note_n = (st_n == HELD) ? {1'b0, hidx_n} : 4'hF;
  end

  // State and registered outputs; pulse marks the first cycle of a new note.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st              <= IDLE;
      hidx            <= '0;
      bus.note        <= 4'hF;
      bus.note_valid  <= 1'b0;
      bus.note_change <= 1'b0;
    end else begin
      st              <= st_n;
      hidx            <= hidx_n;
      bus.note        <= note_n;
      bus.note_valid  <= (st_n == HELD);
      bus.note_change <= (note_n != bus.note);
    end
  end
endmodule

// File: tb/tb_note_key_encoder.sv
// Bench for note_key_encoder: vector table, corner sequences, random keys
// against a cycle-level reference model of the debounce and note rules.
module tb_note_key_encoder;
  localparam int TD  = 4;
  localparam int DEB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  note_key_encoder_if bus ();

  note_key_encoder #(.TICK_DIV(TD), .DEB_COUNT(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  int pulses = 0;
  bit saw_none = 0;

  // Reference state
  logic [7:0] m_s1, m_s2, m_lvl;
  int         m_tc, m_idx;
  int         m_dc [8];
  bit         m_held, m_nv, m_nc;
  logic [3:0] m_note;

  typedef struct {
    logic [7:0] k;
    int         n;
    logic [3:0] en;
    logic       ev;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_tc = 0; m_idx = 0;
    for (int i = 0; i < 8; i++) m_dc[i] = 0;
    m_held = 0; m_nv = 0; m_nc = 0; m_note = 4'hF;
  endtask

  // One rising edge of the reference.
  task automatic model_edge();
    logic [3:0] nn;
    int l;
    if (rst) begin
      model_clear();
      return;
    end
    if (!(m_held && m_lvl[m_idx])) begin
      l = lowest(m_lvl);
      m_held = (l >= 0);
      if (l >= 0) m_idx = l;
    end
    nn     = m_held ? 4'(m_idx) : 4'hF;
    m_nc   = (nn != m_note);
    m_note = nn;
    m_nv   = m_held;
    if (m_tc == TD - 1)
      for (int i = 0; i < 8; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          m_dc[i]++;
          if (m_dc[i] == DEB) begin
            m_lvl[i] = ~m_lvl[i];
            m_dc[i]  = 0;
          end
        end else m_dc[i] = 0;
      end
    m_tc = (m_tc + 1) % TD;
    m_s2 = m_s1;
    m_s1 = bus.keys;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("cyc_note", bus.note, m_note);
    chk("cyc_valid", bus.note_valid, m_nv);
    chk("cyc_change", bus.note_change, m_nc);
    if (bus.note_change) pulses++;
    if (bus.note == 4'hF) saw_none = 1;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int hold;
    bus.keys = '0;
    model_clear();

    tbl[0] = '{8'h04, 20, 4'h2, 1'b1};
    tbl[1] = '{8'h00, 20, 4'hF, 1'b0};
    tbl[2] = '{8'h81, 20, 4'h0, 1'b1};
    tbl[3] = '{8'h80, 20, 4'h7, 1'b1};
    tbl[4] = '{8'h00, 20, 4'hF, 1'b0};
    tbl[5] = '{8'h20, 20, 4'h5, 1'b1};
    tbl[6] = '{8'h22, 20, 4'h5, 1'b1};
    tbl[7] = '{8'h02, 20, 4'h1, 1'b1};
    tbl[8] = '{8'h00, 20, 4'hF, 1'b0};

    // Reset state
    repeat (3) step();
    chk("rst_note", bus.note, 4'hF);
    chk("rst_valid", bus.note_valid, 0);
    chk("rst_change", bus.note_change, 0);
    rst = 1'b0;

    // Steady key 2 from reset: latency bound and single pulse
    bus.keys = 8'h04;
    pulses = 0;
    lat = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (bus.note_valid && lat == 0) lat = c;
    end
    chk("lat_seen", (lat > 0), 1);
    chk("lat_bound", (lat <= 15), 1);
    chk("lat_note", bus.note, 4'h2);
    chk("lat_pulses", pulses, 1);
    bus.keys = 8'h00;
    repeat (20) step();

    // Vector table
    for (int i = 0; i < 9; i++) begin
      bus.keys = tbl[i].k;
      pulses = 0;
      repeat (tbl[i].n) step();
      chk("tbl_note", bus.note, tbl[i].en);
      chk("tbl_valid", bus.note_valid, tbl[i].ev);
      chk("tbl_pulses", pulses, (i == 6) ? 0 : 1);
    end

    // Bouncing key 3 never accepted
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      bus.keys = ((c / 3) % 2 == 1) ? 8'h08 : 8'h00;
      step();
    end
    bus.keys = 8'h00;
    repeat (20) step();
    chk("bounce_pulses", pulses, 0);
    chk("bounce_note", bus.note, 4'hF);

    // Reset while key 6 held
    bus.keys = 8'h40;
    repeat (20) step();
    chk("pre_rst_note", bus.note, 4'h6);
    rst = 1'b1;
    #1;
    model_clear();
    chk("async_rst_note", bus.note, 4'hF);
    chk("async_rst_valid", bus.note_valid, 0);
    chk("async_rst_change", bus.note_change, 0);
    step();
    rst = 1'b0;
    pulses = 0;
    lat = 0;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (bus.note_valid && lat == 0) lat = c;
    end
    chk("rerun_full_deb", (lat >= 9), 1);
    chk("rerun_note", bus.note, 4'h6);
    chk("rerun_pulses", pulses, 1);

    // Release of held key 5 and press of key 2 on the same tick
    bus.keys = 8'h20;
    repeat (20) step();
    chk("swap_pre", bus.note, 4'h5);
    pulses = 0;
    saw_none = 0;
    bus.keys = 8'h04;
    repeat (20) step();
    chk("swap_note", bus.note, 4'h2);
    chk("swap_pulses", pulses, 1);
    chk("swap_no_gap", saw_none, 0);

    // Random keys against the model
    for (int r = 0; r < 400; r++) begin
      case ($urandom_range(0, 3))
        0: bus.keys = 8'($urandom);
        1: bus.keys = 8'h01 << $urandom_range(0, 7);
        2: bus.keys = bus.keys ^ (8'h01 << $urandom_range(0, 7));
        default: bus.keys = 8'h00;
      endcase
      hold = (r % 5 == 0) ? $urandom_range(1, 4) : $urandom_range(5, 30);
      repeat (hold) step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/note_key_encoder.md
NOTE_KEY_ENCODER -- requirements
Module: note_key_encoder

Interface
REQ-001 Parameter TICK_DIV, default 100000, sets the debounce sample period in clk cycles (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 Parameter DEB_COUNT, default 4, sets the number of consecutive identical samples needed to accept a key level; legal range 2..15.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port keys, input, 8 bits: raw, asynchronous piano keys; bit i high means key i pressed.
REQ-006 Port note, output, 4 bits: current note code, 4'h0..4'h7 for keys 0..7, 4'hF for none.
REQ-007 Port note_valid, output, 1 bit: high while note holds a key code.
REQ-008 Port note_change, output, 1 bit: one-cycle pulse on every change of the note value.

Function
REQ-009 Each keys bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-010 A free-running tick counter SHALL assert a one-cycle sample tick every TICK_DIV cycles, wrapping from TICK_DIV-1 to 0.
REQ-011 Per key, on each tick, a sample differing from the accepted level SHALL increment that key's counter, and a sample equal to it SHALL clear the counter.
REQ-012 When a counter reaches DEB_COUNT, the accepted level SHALL toggle and the counter SHALL clear in the same cycle.
REQ-013 Accepted levels SHALL change only on tick cycles.
REQ-014 The FSM SHALL have two states, IDLE and HELD, plus a held-index register hidx[2:0].
REQ-015 IDLE, no accepted key high: remain in IDLE with note=4'hF and note_valid=0.
REQ-016 IDLE, any accepted key high: go to HELD with hidx set to the lowest-index accepted key.
REQ-017 HELD, accepted key hidx still high: remain; newly accepted keys of any index SHALL NOT change hidx.
REQ-018 HELD, key hidx released with other accepted keys high: remain in HELD with hidx set to the lowest-index remaining key.
REQ-019 HELD, key hidx released with no other accepted key high: return to IDLE.
REQ-020 Simultaneous release of hidx and press of another key in the same tick SHALL follow REQ-018, using the updated levels.
REQ-021 note, note_valid and note_change SHALL be registered.
REQ-022 Outputs SHALL update exactly one cycle after the tick on which the accepted level changed.
REQ-023 In HELD, note SHALL equal {1'b0,hidx} and note_valid SHALL be 1.
REQ-024 note_change SHALL be high for exactly the one cycle in which note takes a new value, and never when note is unchanged.
REQ-025 Key indices SHALL map to note codes 0=C high, 1=B, 2=A, 3=G, 4=F, 5=E, 6=D, 7=C low, matching the segment display code set.

Reset
REQ-026 While rst is high, asynchronously: synchronizers, accepted levels, debounce counters and tick counter SHALL be 0; FSM SHALL be IDLE; note=4'hF, note_valid=0, note_change=0.
REQ-027 Assertion of rst mid-debounce or in HELD SHALL discard all progress, with no note_change pulse on reset entry or exit.
REQ-028 After rst deasserts, a key already held SHALL be accepted only after a full DEB_COUNT samples.

Verification (TICK_DIV=4, DEB_COUNT=3)
REQ-029 Scenario: keys=8'h04 steady -> note=4'h2, note_valid=1, one note_change pulse, within 2 (sync) + 3*4 + 1 cycles; no earlier output change.
REQ-030 Scenario: key 3 toggling every 3 cycles for 40 cycles, then low -> note stays 4'hF and note_change never asserts.
REQ-031 Scenario: key 5 held, then key 1 pressed and accepted -> note stays 4'h5; release key 5 -> note=4'h1 with one pulse; release key 1 -> note=4'hF with one pulse.
REQ-032 Scenario: keys 8'h00 to 8'h81 in one cycle -> note=4'h0; release key 0 -> note=4'h7.
REQ-033 Scenario: rst pulsed for 1 cycle while note=4'h6 and key 6 held -> note=4'hF immediately, then 4'h6 again after full re-debounce.
REQ-034 Scenario: accepted release of the held key coinciding with an accepted press of key 2 on the same tick -> note goes directly to 4'h2 with one pulse, never 4'hF.
